// File: rtl/e203_exu_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : e203_exu_flush_ctrl
// Brief    : Registered flush stage between commit and IFU. Exceptions take
//            priority over branches, and the stage holds one flush until the
//            IFU acks it.
// Revision : 1.0 - initial release
// ============================================================================
module e203_exu_flush_ctrl #(
    parameter int PC_SIZE = 32,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               brchmis_flush_req,
    output logic               brchmis_flush_ack,
    input  logic [PC_SIZE-1:0] brchmis_add_op1,
    input  logic [PC_SIZE-1:0] brchmis_add_op2,
    input  logic               excp_flush_req,
    output logic               excp_flush_ack,
    input  logic [PC_SIZE-1:0] excp_flush_pc,
    output logic               ifu_flush_req,
    input  logic               ifu_flush_ack,
    output logic [PC_SIZE-1:0] ifu_flush_pc,
    output logic               ifu_flush_src_excp,
    output logic               flush_busy,
    output logic [CNT_W-1:0]   flush_wait_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PC_SIZE-1:0] r_pc;
    logic               r_src_excp;
    logic [CNT_W-1:0]   r_wait_cnt;

    logic               w_acc_ok;
    logic               w_any_ack;
    logic               w_pend_done;
    logic [PC_SIZE-1:0] w_brch_sum;
    logic [PC_SIZE-1:0] w_brch_pc;
    logic [PC_SIZE-1:0] w_new_pc;

    // A new flush can be taken when idle, or in the same cycle the IFU
    // retires the held one (back-to-back, no bubble).
    assign w_acc_ok          = (r_state == ST_IDLE) | ((r_state == ST_PEND) & ifu_flush_ack);
    assign excp_flush_ack    = w_acc_ok & excp_flush_req;
    assign brchmis_flush_ack = w_acc_ok & brchmis_flush_req & ~excp_flush_req;
    assign w_any_ack         = excp_flush_ack | brchmis_flush_ack;
    assign w_pend_done       = (r_state == ST_PEND) & ifu_flush_ack;

    assign w_brch_sum = brchmis_add_op1 + brchmis_add_op2;
    assign w_brch_pc  = {w_brch_sum[PC_SIZE-1:1], 1'b0};
    assign w_new_pc   = excp_flush_req ? excp_flush_pc : w_brch_pc;

    always_comb begin
        w_state_nxt = r_state;
        if (w_any_ack) begin
            w_state_nxt = ST_PEND;
        end else if (w_pend_done) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_src_excp <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_any_ack) begin
                r_pc       <= w_new_pc;
                r_src_excp <= excp_flush_req;
                r_wait_cnt <= '0;
            end else if (w_pend_done) begin
                r_wait_cnt <= '0;
            end else if ((r_state == ST_PEND) && (r_wait_cnt != C_CNT_MAX)) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    assign flush_busy         = (r_state == ST_PEND);
    assign ifu_flush_req      = flush_busy;
    assign ifu_flush_pc       = r_pc;
    assign ifu_flush_src_excp = r_src_excp;
    assign flush_wait_cnt     = r_wait_cnt;

endmodule
`default_nettype wire

// File: tb/tb_e203_exu_flush_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_e203_exu_flush_ctrl
// Brief    : Directed bench for e203_exu_flush_ctrl. A pending-flush model is
//            compared every cycle, and literal expectations are checked at
//            key points.
// Revision : 1.0 - initial release
// ============================================================================
module tb_e203_exu_flush_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        brchmis_flush_req = 1'b0;
    logic        brchmis_flush_ack;
    logic [31:0] brchmis_add_op1 = '0;
    logic [31:0] brchmis_add_op2 = '0;
    logic        excp_flush_req = 1'b0;
    logic        excp_flush_ack;
    logic [31:0] excp_flush_pc = '0;
    logic        ifu_flush_req;
    logic        ifu_flush_ack = 1'b0;
    logic [31:0] ifu_flush_pc;
    logic        ifu_flush_src_excp;
    logic        flush_busy;
    logic [7:0]  flush_wait_cnt;

    e203_exu_flush_ctrl #(.PC_SIZE(32), .CNT_W(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .brchmis_flush_req  (brchmis_flush_req),
        .brchmis_flush_ack  (brchmis_flush_ack),
        .brchmis_add_op1    (brchmis_add_op1),
        .brchmis_add_op2    (brchmis_add_op2),
        .excp_flush_req     (excp_flush_req),
        .excp_flush_ack     (excp_flush_ack),
        .excp_flush_pc      (excp_flush_pc),
        .ifu_flush_req      (ifu_flush_req),
        .ifu_flush_ack      (ifu_flush_ack),
        .ifu_flush_pc       (ifu_flush_pc),
        .ifu_flush_src_excp (ifu_flush_src_excp),
        .flush_busy         (flush_busy),
        .flush_wait_cnt     (flush_wait_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: at most one outstanding flush, described as (valid, target, source, age).
    bit          m_valid = 1'b0;
    longint      m_pc    = 0;
    bit          m_src   = 1'b0;
    int          m_age   = 0;

    always @(posedge clk) begin
        bit can_take;
        if (rst) begin
            m_valid = 1'b0;
            m_pc    = 0;
            m_src   = 1'b0;
            m_age   = 0;
        end else begin
            can_take = !m_valid || ifu_flush_ack;
            if (can_take && (excp_flush_req || brchmis_flush_req)) begin
                m_valid = 1'b1;
                m_src   = excp_flush_req;
                if (excp_flush_req)
                    m_pc = longint'(excp_flush_pc);
                else
                    m_pc = ((longint'(brchmis_add_op1) + longint'(brchmis_add_op2)) % (64'd1 << 32)) / 2 * 2;
                m_age   = 0;
            end else if (m_valid && ifu_flush_ack) begin
                m_valid = 1'b0;
                m_age   = 0;
            end else if (m_valid) begin
                m_age = (m_age + 1 > 255) ? 255 : m_age + 1;
            end
        end
    end

    always @(negedge clk) begin
        bit can_take;
        if (started) begin
            can_take = !m_valid || ifu_flush_ack;
            check("ifu_flush_req", 64'(ifu_flush_req), 64'(m_valid));
            check("flush_busy", 64'(flush_busy), 64'(m_valid));
            check("ifu_flush_pc", 64'(ifu_flush_pc), 64'(m_pc));
            check("src_excp", 64'(ifu_flush_src_excp), 64'(m_src));
            check("wait_cnt", 64'(flush_wait_cnt), 64'(m_age));
            check("excp_ack", 64'(excp_flush_ack), 64'(can_take && excp_flush_req));
            check("brch_ack", 64'(brchmis_flush_ack),
                  64'(can_take && brchmis_flush_req && !excp_flush_req));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        started = 1'b1;
        check("rst_req", 64'(ifu_flush_req), 64'd0);
        check("rst_pc", 64'(ifu_flush_pc), 64'd0);
        check("rst_cnt", 64'(flush_wait_cnt), 64'd0);

        // Plain branch flush
        brchmis_flush_req = 1'b1;
        brchmis_add_op1 = 32'h8000_0100;
        brchmis_add_op2 = 32'h0000_0040;
        @(negedge clk);
        check("t1_brch_ack", 64'(brchmis_flush_ack), 64'd1);
        step();
        brchmis_flush_req = 1'b0;
        check("t1_req", 64'(ifu_flush_req), 64'd1);
        check("t1_pc", 64'(ifu_flush_pc), 64'h8000_0140);
        check("t1_src", 64'(ifu_flush_src_excp), 64'd0);
        ifu_flush_ack = 1'b1;
        step();
        ifu_flush_ack = 1'b0;
        check("t1_idle", 64'(ifu_flush_req), 64'd0);

        // Exception beats a simultaneous branch; branch holds and goes next
        brchmis_flush_req = 1'b1;
        brchmis_add_op1 = 32'h0000_1000;
        brchmis_add_op2 = 32'h0000_0010;
        excp_flush_req = 1'b1;
        excp_flush_pc = 32'h8000_0000;
        @(negedge clk);
        check("t2_excp_ack", 64'(excp_flush_ack), 64'd1);
        check("t2_brch_ack", 64'(brchmis_flush_ack), 64'd0);
        step();
        excp_flush_req = 1'b0;
        check("t2_pc", 64'(ifu_flush_pc), 64'h8000_0000);
        check("t2_src", 64'(ifu_flush_src_excp), 64'd1);
        @(negedge clk);
        check("t2_brch_wait", 64'(brchmis_flush_ack), 64'd0);
        step();
        ifu_flush_ack = 1'b1;
        @(negedge clk);
        check("t2_brch_ack2", 64'(brchmis_flush_ack), 64'd1);
        step();
        ifu_flush_ack = 1'b0;
        check("t2_pc2", 64'(ifu_flush_pc), 64'h0000_1010);
        check("t2_src2", 64'(ifu_flush_src_excp), 64'd0);

        // Long stall with a branch waiting: counter saturates, no acks
        brchmis_flush_req = 1'b0;
        step();
        brchmis_flush_req = 1'b1;
        brchmis_add_op1 = 32'h0000_2000;
        brchmis_add_op2 = 32'h0000_0004;
        repeat (300) step();
        check("t3_cnt_sat", 64'(flush_wait_cnt), 64'd255);
        check("t3_pc_hold", 64'(ifu_flush_pc), 64'h0000_1010);

        // Back-to-back: IFU ack and new branch in the same cycle
        ifu_flush_ack = 1'b1;
        step();
        ifu_flush_ack = 1'b0;
        brchmis_flush_req = 1'b0;
        check("t4_req", 64'(ifu_flush_req), 64'd1);
        check("t4_pc", 64'(ifu_flush_pc), 64'h0000_2004);
        check("t4_cnt", 64'(flush_wait_cnt), 64'd0);
        repeat (3) step();
        check("t4_cnt3", 64'(flush_wait_cnt), 64'd3);

        // Adder wrap and bit0 clear
        ifu_flush_ack = 1'b1;
        step();
        ifu_flush_ack = 1'b0;
        brchmis_flush_req = 1'b1;
        brchmis_add_op1 = 32'hFFFF_FFFE;
        brchmis_add_op2 = 32'h0000_0004;
        step();
        brchmis_flush_req = 1'b0;
        check("t5_wrap", 64'(ifu_flush_pc), 64'h0000_0002);
        ifu_flush_ack = 1'b1;
        brchmis_flush_req = 1'b1;
        brchmis_add_op1 = 32'h0000_0101;
        brchmis_add_op2 = 32'h0000_0000;
        step();
        brchmis_flush_req = 1'b0;
        ifu_flush_ack = 1'b0;
        check("t5_bit0", 64'(ifu_flush_pc), 64'h0000_0100);

        // Reset mid-PEND drops the flush; normal operation afterwards
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_req", 64'(ifu_flush_req), 64'd0);
        check("t6_pc", 64'(ifu_flush_pc), 64'd0);
        check("t6_cnt", 64'(flush_wait_cnt), 64'd0);
        ifu_flush_ack = 1'b1;
        step();
        check("t6_idle_ack", 64'(ifu_flush_req), 64'd0);
        ifu_flush_ack = 1'b0;
        excp_flush_req = 1'b1;
        excp_flush_pc = 32'h8000_0004;
        step();
        excp_flush_req = 1'b0;
        check("t6_pc2", 64'(ifu_flush_pc), 64'h8000_0004);
        check("t6_src2", 64'(ifu_flush_src_excp), 64'd1);
        repeat (2) step();
        ifu_flush_ack = 1'b1;
        step();
        ifu_flush_ack = 1'b0;
        repeat (2) step();

        started = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
